detonation_sequencer: RTL and testbench
=======================================

Name: detonation_sequencer

Overview:
- Downstream consumer of the 8-bit thermometer progress bar produced by the 10 s self-destruct counter.
- Also consumes the debounced 2-of-3 danger vote and a debounced abort switch.
- Tracks the bar to full, opens a grace window during which abort is honoured, then drives a timed fire pulse, then enters a lockout that requires a clean re-arm.
- Sits between the counter and the LED/actuator output drivers.

Parameters:
- GRACE_TICKS, 300, ticks from bar-full to fire (3 s at 10 ms tick).
- FIRE_TICKS, 50, fire pulse length in ticks.
- LOCKOUT_TICKS, 100, consecutive idle-condition ticks required to leave SAFE.
- CNT_W, 10, width of the shared down-counter; must hold max(GRACE_TICKS, FIRE_TICKS, LOCKOUT_TICKS).

Ports:
- clk  in  1  system clock (12 MHz).
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-clk strobe at 10 ms rate; all timing counts advance only on tick.
- bar  in  8  thermometer progress, filled from LSB (0x00, 0x01, 0x03 ... 0xFF).
- danger_vote  in  1  debounced 2-of-3 danger result.
- abort  in  1  debounced abort switch, level.
- state  out  3  IDLE=0, TRACK=1, ARMED=2, FIRE=3, SAFE=4.
- armed  out  1  high while in ARMED.
- fire  out  1  high while in FIRE.
- buzzer  out  1  toggles on each tick while in ARMED; 0 in all other states.
- fault  out  1  sticky; set on an illegal bar code; cleared only by reset.
- remaining  out  CNT_W  current down-counter value; shown during ARMED/FIRE, 0 elsewhere.

Behaviour:
- Reset (async assert, sync deassert by the clock domain):
  - state=IDLE; armed, fire, buzzer and fault all 0.
  - remaining=0; internal counter=0.
- Outputs are Moore, registered, and change on the same edge as state. Decision-to-output latency is 1 clk.
- Legal bar code: (bar & (bar+1)) == 0. This is checked on tick in TRACK and ARMED.
- IDLE:
  - danger_vote=1 and bar!=0 on a tick -> TRACK.
  - abort is ignored.
- TRACK, evaluated in priority order:
  - abort (any clk) -> SAFE, counter=LOCKOUT_TICKS.
  - Illegal bar on tick -> fault=1, SAFE.
  - danger_vote=0 on tick -> IDLE.
  - bar==0xFF on tick -> ARMED, counter=GRACE_TICKS.
- ARMED:
  - abort (any clk) -> SAFE immediately, even in the same cycle as the counter reaching 0. Abort wins.
  - Illegal bar on tick -> fault=1, SAFE.
  - danger_vote is ignored once armed.
  - On each tick the counter decrements. When the counter is 1 and a tick arrives -> FIRE, counter=FIRE_TICKS.
  - The total ARMED duration is exactly GRACE_TICKS ticks.
- FIRE:
  - abort, bar and danger_vote are ignored.
  - The counter decrements per tick. When the counter is 1 and a tick arrives -> SAFE, counter=LOCKOUT_TICKS.
  - fire is high for exactly FIRE_TICKS ticks.
- SAFE:
  - All outputs low except fault and state.
  - On tick, if abort=0 and bar==0, the counter decrements. Otherwise the counter reloads LOCKOUT_TICKS.
  - When the counter is 1 and a qualifying tick arrives -> IDLE.
- Counter behaviour:
  - The counter never wraps; it saturates at 0.
  - A parameter value of 0 is treated as 1.
- Async reset mid-FIRE drops fire within the same clk (asynchronous).
- Unused state encodings (5-7) -> SAFE on the next clk, fault=1.

Test Plan (GRACE_TICKS=4, FIRE_TICKS=2, LOCKOUT_TICKS=3, tick every 4 clks):
- Nominal: danger_vote=1, bar ramps 0x01->0xFF -> TRACK, then ARMED on the 0xFF tick. remaining reads 4,3,2,1. fire=1 for exactly 2 ticks (8 clks). Then SAFE.
- Abort in grace: as nominal, abort=1 when remaining=2 -> state=SAFE next clk, fire never asserts, buzzer=0.
- Abort/fire collision: abort rises on the same clk as the tick with remaining=1 -> SAFE, fire stays 0.
- Illegal bar: in TRACK, drive bar=0x05 on a tick -> fault=1, state=SAFE. fault persists through the return to IDLE until rst_n=0.
- Lockout exit: in SAFE, hold bar=0, abort=0 -> IDLE after 3 ticks. Pulse abort=1 at tick 2 -> counter reloads, IDLE only after 3 further clean ticks.
- Danger drop: in TRACK, danger_vote=0 on a tick -> IDLE. In ARMED, danger_vote=0 -> no effect, FIRE still reached.

Source files
------------

// File: rtl/detonation_sequencer.sv
// detonation_sequencer
// Follows the thermometer progress bar to full and then opens a grace window
// in which abort is honoured. When the window expires it drives a timed fire
// pulse. After that it holds a lockout that is released only by a clean re-arm.
//
// Handshake/timing contract: there is no valid/ready pair on this block.
// 'tick' is a single-clk strobe, and every timed count advances only on it.
// 'abort' is a level signal sampled on every clk in TRACK and ARMED.
// All outputs are registered Moore outputs and change on the same edge as 'state'.
module detonation_sequencer #(
    parameter int GRACE_TICKS   = 300,
    parameter int FIRE_TICKS    = 50,
    parameter int LOCKOUT_TICKS = 100,
    parameter int CNT_W         = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [7:0]       bar,
    input  logic             danger_vote,
    input  logic             abort,
    output logic [2:0]       state,
    output logic             armed,
    output logic             fire,
    output logic             buzzer,
    output logic             fault,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRACK = 3'd1,
        ST_ARMED = 3'd2,
        ST_FIRE  = 3'd3,
        ST_SAFE  = 3'd4
    } state_t;

    // A zero-length interval would never terminate the down-count, so it is raised to 1
    localparam logic [CNT_W-1:0] GRACE_LOAD   = (GRACE_TICKS   < 1) ? CNT_W'(1) : CNT_W'(GRACE_TICKS);
    localparam logic [CNT_W-1:0] FIRE_LOAD    = (FIRE_TICKS    < 1) ? CNT_W'(1) : CNT_W'(FIRE_TICKS);
    localparam logic [CNT_W-1:0] LOCKOUT_LOAD = (LOCKOUT_TICKS < 1) ? CNT_W'(1) : CNT_W'(LOCKOUT_TICKS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             buzzer_q, buzzer_d;
    logic             armed_q, fire_q;
    logic [CNT_W-1:0] remaining_q;

    logic [7:0]       bar_inc;
    logic             bar_legal;
    logic [CNT_W-1:0] cnt_dec;
    logic             cnt_last;

    // A thermometer code plus one is a power of two, so the two share no set bits
    assign bar_inc   = bar + 8'd1;
    assign bar_legal = ((bar & bar_inc) == 8'd0);

    // The down-counter saturates at zero; zero and one both count as the final tick
    assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    assign cnt_last = (cnt_q <= CNT_W'(1));

    // Next-state, counter and sticky-fault decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (tick && danger_vote && (bar != 8'd0)) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                cnt_d = '0;
                if (abort) begin
                    state_d = ST_SAFE;
                    cnt_d   = LOCKOUT_LOAD;
                end else if (tick) begin
                    if (!bar_legal) begin
                        fault_d = 1'b1;
                        state_d = ST_SAFE;
                        cnt_d   = LOCKOUT_LOAD;
                    end else if (!danger_vote) begin
                        state_d = ST_IDLE;
                    end else if (bar == 8'hFF) begin
                        state_d = ST_ARMED;
                        cnt_d   = GRACE_LOAD;
                    end
                end
            end
            ST_ARMED: begin
                // Abort is checked first, so it wins even on the tick that would fire
                if (abort) begin
                    state_d = ST_SAFE;
                    cnt_d   = LOCKOUT_LOAD;
                end else if (tick) begin
                    if (!bar_legal) begin
                        fault_d = 1'b1;
                        state_d = ST_SAFE;
                        cnt_d   = LOCKOUT_LOAD;
                    end else if (cnt_last) begin
                        state_d = ST_FIRE;
                        cnt_d   = FIRE_LOAD;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
            end
            ST_FIRE: begin
                if (tick) begin
                    if (cnt_last) begin
                        state_d = ST_SAFE;
                        cnt_d   = LOCKOUT_LOAD;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
            end
            ST_SAFE: begin
                if (tick) begin
                    if (!abort && (bar == 8'd0)) begin
                        if (cnt_last) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_dec;
                        end
                    end else begin
                        cnt_d = LOCKOUT_LOAD;
                    end
                end
            end
            default: begin
                // A corrupted state register is treated as a fault and forced into lockout
                fault_d = 1'b1;
                state_d = ST_SAFE;
                cnt_d   = LOCKOUT_LOAD;
            end
        endcase
    end

    // Buzzer toggles per tick only while remaining in ARMED and starts low on entry
    always_comb begin
        buzzer_d = 1'b0;
        if ((state_d == ST_ARMED) && (state_q == ST_ARMED)) begin
            buzzer_d = buzzer_q ^ tick;
        end
    end

    // State, counter and registered Moore outputs; async reset drops fire at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            buzzer_q    <= 1'b0;
            armed_q     <= 1'b0;
            fire_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
            buzzer_q    <= buzzer_d;
            armed_q     <= (state_d == ST_ARMED);
            fire_q      <= (state_d == ST_FIRE);
            remaining_q <= ((state_d == ST_ARMED) || (state_d == ST_FIRE)) ? cnt_d : '0;
        end
    end

    assign state     = state_q;
    assign armed     = armed_q;
    assign fire      = fire_q;
    assign buzzer    = buzzer_q;
    assign fault     = fault_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_detonation_sequencer.sv
// tb_detonation_sequencer
// Runs a directed sequence through the nominal, abort, collision, lockout,
// danger-drop and illegal-bar cases, using GRACE=4, FIRE=2, LOCKOUT=3 and a
// tick on every fourth clk.
module tb_detonation_sequencer;

    localparam int CNT_W = 10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRACK = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_FIRE  = 3'd3;
    localparam logic [2:0] S_SAFE  = 3'd4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tick;
    logic [7:0]       bar;
    logic             danger_vote;
    logic             abort;
    logic [2:0]       state;
    logic             armed;
    logic             fire;
    logic             buzzer;
    logic             fault;
    logic [CNT_W-1:0] remaining;

    logic [16:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    detonation_sequencer #(
        .GRACE_TICKS  (4),
        .FIRE_TICKS   (2),
        .LOCKOUT_TICKS(3),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .bar        (bar),
        .danger_vote(danger_vote),
        .abort      (abort),
        .state      (state),
        .armed      (armed),
        .fire       (fire),
        .buzzer     (buzzer),
        .fault      (fault),
        .remaining  (remaining)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Expected output word: {fault, buzzer, fire, armed, state, remaining}
    function automatic logic [16:0] exp_word(input logic [2:0] st, input int rem,
                                             input logic bz, input logic flt);
        logic [CNT_W-1:0] r;
        r = CNT_W'(rem);
        return {flt, bz, (st == S_FIRE), (st == S_ARMED), st, r};
    endfunction

    function automatic logic [16:0] obs_word();
        return {fault, buzzer, fire, armed, state, remaining};
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got flt=%b bz=%b fire=%b arm=%b st=%0d rem=%0d, expected flt=%b bz=%b fire=%b arm=%b st=%0d rem=%0d",
                     tag, obs[16], obs[15], obs[14], obs[13], obs[12:10], obs[9:0],
                     exp[16], exp[15], exp[14], exp[13], exp[12:10], exp[9:0]);
        end else begin
            n_pass++;
        end
    endtask

    // driver: one clk with the given inputs, sampled #1 after the edge
    task automatic step(input logic tk, input logic [7:0] b, input logic dv, input logic ab);
        @(negedge clk);
        tick        = tk;
        bar         = b;
        danger_vote = dv;
        abort       = ab;
        @(posedge clk);
        #1;
    endtask

    // one clk with expectation pushed at drive time and compared after the edge
    task automatic clk_chk(input string tag, input logic tk, input logic [7:0] b,
                           input logic dv, input logic ab, input logic [16:0] exp);
        exp_q.push_back(exp);
        step(tk, b, dv, ab);
        check(tag, obs_word(), exp_q.pop_front());
    endtask

    // one tick period: three quiet clks then the tick clk, checked after the tick
    task automatic period(input string tag, input logic [7:0] b, input logic dv,
                          input logic ab_pre, input logic ab_tk, input logic [16:0] exp);
        exp_q.push_back(exp);
        for (int i = 0; i < 3; i++) step(1'b0, b, dv, ab_pre);
        step(1'b1, b, dv, ab_tk);
        check(tag, obs_word(), exp_q.pop_front());
    endtask

    initial begin
        rst_n       = 1'b0;
        tick        = 1'b0;
        bar         = 8'h00;
        danger_vote = 1'b0;
        abort       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(exp_word(S_IDLE, 0, 0, 0));
        check("reset", obs_word(), exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE boundaries: empty bar does not start tracking, abort ignored
        period("idle_bar0",  8'h00, 1, 1, 1, exp_word(S_IDLE, 0, 0, 0));
        period("idle_nodv",  8'h01, 0, 0, 0, exp_word(S_IDLE, 0, 0, 0));

        // Nominal run
        period("nom_track",  8'h01, 1, 0, 0, exp_word(S_TRACK, 0, 0, 0));
        period("nom_03",     8'h03, 1, 0, 0, exp_word(S_TRACK, 0, 0, 0));
        period("nom_0f",     8'h0F, 1, 0, 0, exp_word(S_TRACK, 0, 0, 0));
        period("nom_armed4", 8'hFF, 1, 0, 0, exp_word(S_ARMED, 4, 0, 0));
        period("nom_armed3", 8'hFF, 1, 0, 0, exp_word(S_ARMED, 3, 1, 0));
        period("nom_armed2", 8'hFF, 1, 0, 0, exp_word(S_ARMED, 2, 0, 0));
        period("nom_armed1", 8'hFF, 1, 0, 0, exp_word(S_ARMED, 1, 1, 0));
        period("nom_fire2",  8'hFF, 1, 0, 0, exp_word(S_FIRE, 2, 0, 0));
        period("nom_fire1",  8'hFF, 1, 0, 0, exp_word(S_FIRE, 1, 0, 0));
        period("nom_safe",   8'hFF, 1, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("nom_reload", 8'hFF, 1, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("nom_lock1",  8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("nom_lock2",  8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("nom_idle",   8'h00, 0, 0, 0, exp_word(S_IDLE, 0, 0, 0));

        // Abort during grace, off-tick, at remaining=2
        period("ga_track",   8'h01, 1, 0, 0, exp_word(S_TRACK, 0, 0, 0));
        period("ga_armed4",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 4, 0, 0));
        period("ga_armed3",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 3, 1, 0));
        period("ga_armed2",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 2, 0, 0));
        clk_chk("ga_abort", 1'b0, 8'hFF, 1, 1, exp_word(S_SAFE, 0, 0, 0));
        period("ga_held",    8'hFF, 1, 1, 1, exp_word(S_SAFE, 0, 0, 0));
        period("ga_lock1",   8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("ga_lock2",   8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("ga_idle",    8'h00, 0, 0, 0, exp_word(S_IDLE, 0, 0, 0));

        // Abort on the same clk as the final grace tick
        period("co_track",   8'h01, 1, 0, 0, exp_word(S_TRACK, 0, 0, 0));
        period("co_armed4",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 4, 0, 0));
        period("co_armed3",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 3, 1, 0));
        period("co_armed2",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 2, 0, 0));
        period("co_armed1",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 1, 1, 0));
        period("co_collide", 8'hFF, 1, 0, 1, exp_word(S_SAFE, 0, 0, 0));

        // Lockout with an abort pulse on the second tick reloads the count
        period("lo_tick1",   8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("lo_abort2",  8'h00, 0, 0, 1, exp_word(S_SAFE, 0, 0, 0));
        period("lo_clean1",  8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("lo_clean2",  8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("lo_idle",    8'h00, 0, 0, 0, exp_word(S_IDLE, 0, 0, 0));

        // Danger drop: honoured in TRACK, ignored in ARMED
        period("dd_track",   8'h01, 1, 0, 0, exp_word(S_TRACK, 0, 0, 0));
        period("dd_drop",    8'h03, 0, 0, 0, exp_word(S_IDLE, 0, 0, 0));
        period("dd_track2",  8'h01, 1, 0, 0, exp_word(S_TRACK, 0, 0, 0));
        period("dd_armed4",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 4, 0, 0));
        period("dd_armed3",  8'hFF, 0, 0, 0, exp_word(S_ARMED, 3, 1, 0));
        period("dd_armed2",  8'hFF, 0, 0, 0, exp_word(S_ARMED, 2, 0, 0));
        period("dd_armed1",  8'hFF, 0, 0, 0, exp_word(S_ARMED, 1, 1, 0));
        period("dd_fire2",   8'hFF, 0, 0, 0, exp_word(S_FIRE, 2, 0, 0));
        clk_chk("dd_fire_abort_ign", 1'b0, 8'h05, 0, 1, exp_word(S_FIRE, 2, 0, 0));
        period("dd_fire1",   8'hFF, 0, 0, 0, exp_word(S_FIRE, 1, 0, 0));
        period("dd_safe",    8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("dd_lock1",   8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("dd_lock2",   8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 0));
        period("dd_idle",    8'h00, 0, 0, 0, exp_word(S_IDLE, 0, 0, 0));

        // Illegal bar in TRACK: sticky fault persists through the return to IDLE
        period("ib_track",   8'h01, 1, 0, 0, exp_word(S_TRACK, 0, 0, 0));
        period("ib_illegal", 8'h05, 1, 0, 0, exp_word(S_SAFE, 0, 0, 1));
        period("ib_lock1",   8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 1));
        period("ib_lock2",   8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 1));
        period("ib_idle",    8'h00, 0, 0, 0, exp_word(S_IDLE, 0, 0, 1));
        period("ib_track2",  8'h01, 1, 0, 0, exp_word(S_TRACK, 0, 0, 1));
        period("ib_armed4",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 4, 0, 1));
        period("ib_armed3",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 3, 1, 1));
        period("ib_armed2",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 2, 0, 1));
        period("ib_armed1",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 1, 1, 1));
        period("ib_fire2",   8'hFF, 1, 0, 0, exp_word(S_FIRE, 2, 0, 1));

        // Asynchronous reset mid-FIRE clears fire and fault without a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(exp_word(S_IDLE, 0, 0, 0));
        check("async_rst_fire", obs_word(), exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        period("post_rst",   8'h00, 0, 0, 0, exp_word(S_IDLE, 0, 0, 0));

        // Illegal bar while ARMED; a different legal code keeps counting
        period("ia_track",   8'h01, 1, 0, 0, exp_word(S_TRACK, 0, 0, 0));
        period("ia_armed4",  8'hFF, 1, 0, 0, exp_word(S_ARMED, 4, 0, 0));
        period("ia_legal7f", 8'h7F, 1, 0, 0, exp_word(S_ARMED, 3, 1, 0));
        period("ia_illegal", 8'hFE, 1, 0, 0, exp_word(S_SAFE, 0, 0, 1));

        // TRACK abort on a non-tick clk
        period("ta_lock1",   8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 1));
        period("ta_lock2",   8'h00, 0, 0, 0, exp_word(S_SAFE, 0, 0, 1));
        period("ta_idle",    8'h00, 0, 0, 0, exp_word(S_IDLE, 0, 0, 1));
        period("ta_track",   8'h01, 1, 0, 0, exp_word(S_TRACK, 0, 0, 1));
        clk_chk("ta_abort", 1'b0, 8'h03, 1, 1, exp_word(S_SAFE, 0, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
